// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM encoding and scoreboard-free helpers for the
// sequential 16-bit binary to BCD converter (double-dabble).
package bin2bcd_pkg;

    // Default width of the binary operand.
    localparam int LARGURA_BIN = 16;

    // Default number of BCD digits produced (65535 needs five).
    localparam int NUM_DIGITOS = 5;

    // One shift per input bit, so a conversion takes this many cycles.
    localparam int NUM_CICLOS = 16;

    // Controller states.
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        PRONTO   = 2'd2
    } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Per-digit double-dabble correction: a digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
module ajuste_bcd (
    input  logic [3:0] digito_i,
    output logic [3:0] digito_o
);

    // Add-3 correction for digits in the range 5..9.
    always_comb begin
        if (digito_i >= 4'd5) begin
            digito_o = digito_i + 4'd3;
        end else begin
            digito_o = digito_i;
        end
    end

endmodule

// File: rtl/bin2bcd_16b.sv
// Sequential binary to packed-BCD converter. A start request captures the
// operand, then one double-dabble step runs per clock; the previous result
// stays visible on bcd/ndigitos until the new one is complete.
module bin2bcd_16b
    import bin2bcd_pkg::estado_t;
    import bin2bcd_pkg::OCIOSO;
    import bin2bcd_pkg::CONVERTE;
    import bin2bcd_pkg::PRONTO;
    import bin2bcd_pkg::NUM_CICLOS;
#(
    parameter int LARGURA_BIN = bin2bcd_pkg::LARGURA_BIN,
    parameter int NUM_DIGITOS = bin2bcd_pkg::NUM_DIGITOS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 inicio,
    input  logic [LARGURA_BIN-1:0]               binario,
    output logic [4*NUM_DIGITOS-1:0]             bcd,
    output logic [$clog2(NUM_DIGITOS+1)-1:0]     ndigitos,
    output logic                                 ocupado,
    output logic                                 fim
);

    localparam int LARGURA_BCD  = 4 * NUM_DIGITOS;
    localparam int LARGURA_ND   = $clog2(NUM_DIGITOS + 1);
    localparam int LARGURA_CONT = $clog2(NUM_CICLOS);

    localparam logic [LARGURA_CONT-1:0] ULTIMO_CICLO = LARGURA_CONT'(NUM_CICLOS - 1);

    estado_t                 estado_q, estado_d;
    logic [LARGURA_BIN-1:0]  desl_q, desl_d;     // operand shift register
    logic [LARGURA_BCD-1:0]  acc_q, acc_d;       // BCD accumulator
    logic [LARGURA_CONT-1:0] cont_q, cont_d;     // shifts performed so far
    logic [LARGURA_BCD-1:0]  bcd_q, bcd_d;       // visible result
    logic [LARGURA_ND-1:0]   ndig_q, ndig_d;     // visible digit count

    logic [LARGURA_BCD-1:0]  acc_corr;           // accumulator after add-3
    logic [LARGURA_BCD-1:0]  acc_desl;           // accumulator after shift
    logic [LARGURA_BIN-1:0]  desl_desl;          // operand after shift
    logic [LARGURA_ND-1:0]   ndig_calc;          // digit count of acc_desl

    for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .digito_i (acc_q[4*g +: 4]),
            .digito_o (acc_corr[4*g +: 4])
        );
    end

    // One double-dabble step: shift the corrected accumulator and operand as one word.
    always_comb begin
        {acc_desl, desl_desl} = {acc_corr, desl_q} << 1;
    end

    // Significant digits of the freshly shifted accumulator; zero counts as one digit.
    always_comb begin
        ndig_calc = LARGURA_ND'(1);
        for (int i = 1; i < NUM_DIGITOS; i++) begin
            if (acc_desl[4*i +: 4] != 4'd0) begin
                ndig_calc = LARGURA_ND'(i + 1);
            end
        end
    end

    // Next-state and datapath control.
    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        estado_d = estado_q;
        desl_d   = desl_q;
        acc_d    = acc_q;
        cont_d   = cont_q;
        bcd_d    = bcd_q;
        ndig_d   = ndig_q;

        case (estado_q)
            OCIOSO, PRONTO: begin
                if (inicio) begin
                    desl_d   = binario;
                    acc_d    = '0;
                    cont_d   = '0;
                    estado_d = CONVERTE;
                end
            end
            CONVERTE: begin
                acc_d  = acc_desl;
                desl_d = desl_desl;
                cont_d = cont_q + 1'b1;
                if (cont_q == ULTIMO_CICLO) begin
                    bcd_d    = acc_desl;
                    ndig_d   = ndig_calc;
                    estado_d = PRONTO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= OCIOSO;
            desl_q   <= '0;
            acc_q    <= '0;
            cont_q   <= '0;
            bcd_q    <= '0;
            ndig_q   <= LARGURA_ND'(1);
        end else begin
            estado_q <= estado_d;
            desl_q   <= desl_d;
            acc_q    <= acc_d;
            cont_q   <= cont_d;
            bcd_q    <= bcd_d;
            ndig_q   <= ndig_d;
        end
    end

    assign bcd      = bcd_q;
    assign ndigitos = ndig_q;
    assign ocupado  = (estado_q == CONVERTE);
    assign fim      = (estado_q == PRONTO);

endmodule

// File: tb/tb_bin2bcd_16b.sv
// Directed self-checking bench for bin2bcd_16b with an expected-result queue.
module tb_bin2bcd_16b;

    typedef struct {
        logic [19:0] bcd;
        logic [2:0]  nd;
    } esperado_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inicio;
    logic [15:0] binario;
    logic [19:0] bcd;
    logic [2:0]  ndigitos;
    logic        ocupado;
    logic        fim;

    esperado_t   sb[$];
    logic [19:0] last_bcd;
    int          vectors    = 0;
    int          miscompares = 0;

    bin2bcd_16b #(
        .LARGURA_BIN (16),
        .NUM_DIGITOS (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inicio   (inicio),
        .binario  (binario),
        .bcd      (bcd),
        .ndigitos (ndigitos),
        .ocupado  (ocupado),
        .fim      (fim)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division.
    function automatic esperado_t modelo(input int v);
        esperado_t e;
        int x = v;
        for (int i = 0; i < 5; i++) begin
            e.bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.nd = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (e.bcd[4*i +: 4] != 4'd0) e.nd = 3'(i + 1);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand with a one-cycle start pulse and check the accept edge.
    task automatic start(input int v);
        binario = 16'(v);
        inicio  = 1'b1;
        sb.push_back(modelo(v));
        tick();
        inicio = 1'b0;
        check("accept ocupado", 32'(ocupado), 32'd1);
        check("accept fim", 32'(fim), 32'd0);
        check("accept bcd hold", 32'(bcd), 32'(last_bcd));
    endtask

    // Wait (bounded) for completion, checking hold/exclusivity and the result.
    task automatic wait_done(input string tag, input int elapsed);
        esperado_t e;
        int n = elapsed;
        while (!fim && n < 40) begin
            check({tag, " busy hold"}, 32'(bcd), 32'(last_bcd));
            check({tag, " ocupado"}, 32'(ocupado), 32'd1);
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd16);
        check({tag, " ocupado done"}, 32'(ocupado), 32'd0);
        if (fim) begin
            check({tag, " queue"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, " bcd"}, 32'(bcd), 32'(e.bcd));
                check({tag, " ndigitos"}, 32'(ndigitos), 32'(e.nd));
                last_bcd = e.bcd;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        esperado_t e;
        int        since;
        int        nfim;
        logic      saw_activity;

        rst      = 1'b1;
        inicio   = 1'b0;
        binario  = '0;
        last_bcd = '0;

        // Asynchronous reset state before any clock edge.
        #2;
        check("reset bcd", 32'(bcd), 32'd0);
        check("reset ndigitos", 32'(ndigitos), 32'd1);
        check("reset fim", 32'(fim), 32'd0);
        check("reset ocupado", 32'(ocupado), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 300 -> three digits.
        start(300);
        wait_done("v300", 0);

        // Zero -> one digit.
        start(0);
        wait_done("v0", 0);

        // Maximum value, then a new start from PRONTO.
        start(65535);
        wait_done("v65535", 0);
        tick();
        check("pronto fim hold", 32'(fim), 32'd1);
        start(120);
        wait_done("v120", 0);

        // Start request and operand change during conversion are ignored.
        start(6);
        repeat (4) tick();
        binario = 16'd9999;
        inicio  = 1'b1;
        tick();
        inicio  = 1'b0;
        check("ignored ocupado", 32'(ocupado), 32'd1);
        wait_done("v6", 5);

        // Reset in the middle of a conversion.
        start(1234);
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort bcd", 32'(bcd), 32'd0);
        check("abort ndigitos", 32'(ndigitos), 32'd1);
        check("abort fim", 32'(fim), 32'd0);
        check("abort ocupado", 32'(ocupado), 32'd0);
        sb.delete();
        last_bcd = '0;
        inicio = 1'b1;          // edge while rst is still high: must be ignored
        tick();
        inicio = 1'b0;
        rst = 1'b0;
        saw_activity = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (fim || ocupado) saw_activity = 1'b1;
        end
        check("no result after abort", 32'(saw_activity), 32'd0);
        check("abort bcd stays", 32'(bcd), 32'd0);

        // Start held high: back-to-back conversions, fim every 17 cycles.
        binario = 16'd4321;
        inicio  = 1'b1;
        sb.push_back(modelo(4321));
        tick();
        since = 0;
        nfim  = 0;
        for (int c = 0; c < 80 && nfim < 3; c++) begin
            tick();
            since++;
            check("held excl", 32'(fim & ocupado), 32'd0);
            if (fim) begin
                check("held period", 32'(since), (nfim == 0) ? 32'd16 : 32'd17);
                e = sb.pop_front();
                check("held bcd", 32'(bcd), 32'(e.bcd));
                check("held ndigitos", 32'(ndigitos), 32'(e.nd));
                since = 0;
                nfim++;
                if (nfim < 3) sb.push_back(modelo(4321));
                else          inicio = 1'b0;
            end
        end
        check("held fim count", 32'(nfim), 32'd3);
        tick();
        check("held final fim", 32'(fim), 32'd1);
        check("held final ocupado", 32'(ocupado), 32'd0);
        check("queue drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin2bcd_16b.md
BIN2BCD_16B -- requirements
Module: bin2bcd_16b

Interface
REQ-001 SHALL have parameter LARGURA_BIN, default 16, width of the binary input.
REQ-002 SHALL have parameter NUM_DIGITOS, default 5, number of BCD digits output.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port inicio  input  1  start request, sampled on rising clk.
REQ-006 SHALL have port binario  input  16  unsigned value, typically the multiplier's produto.
REQ-007 SHALL have port bcd  output  20  packed BCD result, digit 4 (ten-thousands) in [19:16], digit 0 (units) in [3:0].
REQ-008 SHALL have port ndigitos  output  3  count of significant digits in bcd, 1..5.
REQ-009 SHALL have port ocupado  output  1  high while a conversion is in progress.
REQ-010 SHALL have port fim  output  1  high while a completed result is held on bcd/ndigitos.

Function
REQ-011 SHALL implement the FSM states OCIOSO, CONVERTE, and PRONTO.
REQ-012 SHALL, in OCIOSO or PRONTO, on an edge with inicio=1, capture binario into a 16-bit shift register, clear the 20-bit BCD accumulator, clear counter cont, drop fim, and go to CONVERTE.
REQ-013 SHALL ignore inicio while in CONVERTE, so binario changes during conversion have no effect.
REQ-014 SHALL, at each edge in CONVERTE, add 3 to every accumulator digit ≥5, then shift {accumulator, shift register} left 1 bit and increment cont (double-dabble).
REQ-015 SHALL, on the edge performing the 16th shift (cont=15), load bcd and ndigitos from the final accumulator, set fim=1, and go to PRONTO.
REQ-016 SHALL have a latency such that, with inicio sampled at edge N, fim=1 and bcd valid after edge N+16, giving 16 cycles per conversion.
REQ-017 SHALL hold bcd and ndigitos at the previous result throughout CONVERTE and change them only on completion.
REQ-018 SHALL hold fim=1 in PRONTO until the next accepted inicio; fim SHALL drop on that same edge.
REQ-019 SHALL assert ocupado exactly in CONVERTE; ocupado and fim SHALL never be high together.
REQ-020 SHALL set ndigitos to 1 + index of the highest nonzero digit, and to 1 when the value is 0.
REQ-021 SHALL produce every bcd digit in 0..9; the maximum input 65535 SHALL fit without overflow.
REQ-022 SHALL, when inicio stays high across PRONTO, start a new conversion on each accepted edge, with no extra idle cycle required.

Reset
REQ-023 SHALL, on rst=1, asynchronously force state OCIOSO, bcd=0, ndigitos=1, fim=0, ocupado=0, cont=0, and shift registers to 0.
REQ-024 SHALL abort a conversion when rst asserts during CONVERTE, leave no partial result visible, and require a new inicio after release.
REQ-025 SHALL ignore inicio on the first edge after rst deasserts only if rst is still high at that edge; otherwise it is accepted normally.

Structure
REQ-026 SHALL place LARGURA_BIN, NUM_DIGITOS, the cycle count (16), and the FSM state encoding in the shared package bin2bcd_pkg.
REQ-027 SHALL put the per-digit add-3 correction in a combinational sub-module ajuste_bcd (4-bit in, 4-bit out), instantiated NUM_DIGITOS times.
REQ-028 SHALL contain no other sub-modules, and the counter, FSM, and datapath SHALL reside in bin2bcd_16b.

Verification
REQ-029 SHALL be verified by this scenario: binario=300, inicio pulse 1 cycle -> after 16 edges fim=1, bcd=20'h00300, ndigitos=3, ocupado=0.
REQ-030 SHALL be verified by this scenario: binario=0 -> bcd=20'h00000, ndigitos=1, fim=1 after 16 edges.
REQ-031 SHALL be verified by this scenario: binario=65535 -> bcd=20'h65535, ndigitos=5; then binario=120 with a new inicio -> fim drops on that edge, bcd stays 20'h65535 during conversion, then bcd=20'h00120, ndigitos=3.
REQ-032 SHALL be verified by this scenario: binario=6, inicio pulse; at cycle 5 set binario=9999 and pulse inicio -> ignored; result bcd=20'h00006, ndigitos=1.
REQ-033 SHALL be verified by this scenario: binario=1234, assert rst at cycle 8 of CONVERTE -> immediately bcd=0, ndigitos=1, fim=0, ocupado=0; after release, no fim without a new inicio.
REQ-034 SHALL be verified by this scenario: inicio held high continuously with binario=4321 -> fim pulses high one cycle every 17 cycles, bcd=20'h04321.
